// File: rtl/snn_pkg.sv
// Shared SNN datapath constants and helpers, common to the synapse and the neuron.
package snn_pkg;

  localparam int DEF_N_INPUTS      = 4;
  localparam int DEF_WEIGHT_WIDTH  = 8;
  localparam int DEF_CURRENT_WIDTH = 8;
  localparam int DEF_ACC_WIDTH     = 16;
  localparam int DEF_DECAY_SHIFT   = 3;

  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic wide_t sat_to_width(wide_t x, int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Address width for an N-entry bank; never zero bits wide.
  function automatic int addr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_synapse_if.sv
// Weight-write handshake bundle between a configuring master and the synapse.
interface spike_synapse_if
  import snn_pkg::*;
#(
  parameter int N_INPUTS     = DEF_N_INPUTS,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
) ();

  localparam int AW = addr_w(N_INPUTS);

  logic                           w_valid;
  logic                           w_ready;
  logic [AW-1:0]                  w_addr;
  logic signed [WEIGHT_WIDTH-1:0] w_data;

  modport master (output w_valid, output w_addr, output w_data, input w_ready);
  modport slave  (input w_valid, input w_addr, input w_data, output w_ready);

endinterface

// File: rtl/synapse_weight_bank.sv
// Per-input weight storage: combinational read, registered write with a
// one-cycle ready drop after every accepted write.
module synapse_weight_bank
  import snn_pkg::*;
#(
  parameter int N_INPUTS     = DEF_N_INPUTS,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  spike_synapse_if.slave                 wr,
  output logic signed [WEIGHT_WIDTH-1:0] weight_o [N_INPUTS]
);

  logic signed [WEIGHT_WIDTH-1:0] weight_q [N_INPUTS];
  logic signed [WEIGHT_WIDTH-1:0] weight_d [N_INPUTS];
  logic                           w_ready_q;
  logic                           w_ready_d;
  logic                           accept;

  always_comb begin
    accept    = wr.w_valid && w_ready_q;
    w_ready_d = !accept;
    for (int i = 0; i < N_INPUTS; i++) weight_d[i] = weight_q[i];
    if (accept && (int'(wr.w_addr) < N_INPUTS)) weight_d[wr.w_addr] = wr.w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ready_q <= 1'b1;
      for (int i = 0; i < N_INPUTS; i++) weight_q[i] <= '0;
    end else begin
      w_ready_q <= w_ready_d;
      for (int i = 0; i < N_INPUTS; i++) weight_q[i] <= weight_d[i];
    end
  end

  assign wr.w_ready = w_ready_q;
  assign weight_o   = weight_q;

endmodule

// File: rtl/spike_synapse.sv
// Weighted spike summation feeding a leaky, saturating synaptic-current
// accumulator; output is the accumulator's top CURRENT_WIDTH bits.
module spike_synapse
  import snn_pkg::*;
#(
  parameter int N_INPUTS      = DEF_N_INPUTS,
  parameter int WEIGHT_WIDTH  = DEF_WEIGHT_WIDTH,
  parameter int CURRENT_WIDTH = DEF_CURRENT_WIDTH,
  parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter int DECAY_SHIFT   = DEF_DECAY_SHIFT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_INPUTS-1:0]             spike_in,
  input  logic                            enable,
  spike_synapse_if.slave                  wr,
  output logic signed [CURRENT_WIDTH-1:0] current_out,
  output logic                            current_valid,
  output logic                            sat_flag,
  input  logic                            sat_clr
);

  localparam int AW        = addr_w(N_INPUTS);
  localparam int SUM_W     = WEIGHT_WIDTH + AW;
  localparam int ACC_SHIFT = ACC_WIDTH - WEIGHT_WIDTH;
  localparam int OUT_SHIFT = ACC_WIDTH - CURRENT_WIDTH;
  localparam int FULL_W    = ACC_WIDTH + AW + 2;

  logic signed [WEIGHT_WIDTH-1:0]  weight [N_INPUTS];

  logic signed [SUM_W-1:0]         sum_p1_q, sum_p1_d;
  logic                            vld_p1_q, vld_p1_d;
  logic signed [ACC_WIDTH-1:0]     acc_p2_q, acc_p2_d;
  logic                            vld_p2_q, vld_p2_d;
  logic signed [CURRENT_WIDTH-1:0] current_out_q, current_out_d;
  logic                            current_valid_q, current_valid_d;
  logic                            sat_flag_q, sat_flag_d;

  logic signed [FULL_W-1:0]        acc_ext, decay, inject, acc_full;
  wide_t                           full_wide, acc_sat;
  logic                            clamp;

  synapse_weight_bank #(
    .N_INPUTS     (N_INPUTS),
    .WEIGHT_WIDTH (WEIGHT_WIDTH)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wr),
    .weight_o (weight)
  );

  // Stage 1: sum the weights of active inputs, read before any same-edge write.
  always_comb begin
    sum_p1_d = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (spike_in[i] && enable) sum_p1_d = sum_p1_d + SUM_W'(weight[i]);
    end
    vld_p1_d = 1'b1;
  end

  // Stage 2: leak by an arithmetic shift, inject the scaled sum, clamp.
  always_comb begin
    acc_ext   = FULL_W'(acc_p2_q);
    decay     = FULL_W'(acc_p2_q >>> DECAY_SHIFT);
    inject    = FULL_W'(sum_p1_q) <<< ACC_SHIFT;
    acc_full  = acc_ext - decay + inject;
    full_wide = wide_t'(acc_full);
    acc_sat   = sat_to_width(full_wide, ACC_WIDTH);
    clamp     = (acc_sat != full_wide);
    acc_p2_d  = acc_sat[ACC_WIDTH-1:0];
    vld_p2_d  = vld_p1_q;
    sat_flag_d = clamp ? 1'b1 : (sat_clr ? 1'b0 : sat_flag_q);
  end

  // Output stage: top bits of the accumulator, floor-truncated.
  always_comb begin
    current_out_d   = CURRENT_WIDTH'(acc_p2_q >>> OUT_SHIFT);
    current_valid_d = current_valid_q | vld_p2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1_q        <= '0;
      vld_p1_q        <= 1'b0;
      acc_p2_q        <= '0;
      vld_p2_q        <= 1'b0;
      current_out_q   <= '0;
      current_valid_q <= 1'b0;
      sat_flag_q      <= 1'b0;
    end else begin
      sum_p1_q        <= sum_p1_d;
      vld_p1_q        <= vld_p1_d;
      acc_p2_q        <= acc_p2_d;
      vld_p2_q        <= vld_p2_d;
      current_out_q   <= current_out_d;
      current_valid_q <= current_valid_d;
      sat_flag_q      <= sat_flag_d;
    end
  end

  assign current_out   = current_out_q;
  assign current_valid = current_valid_q;
  assign sat_flag      = sat_flag_q;

endmodule

// File: tb/tb_spike_synapse.sv
// Scoreboard bench for spike_synapse: a cycle model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_spike_synapse;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [3:0]          spike_in;
  logic                enable;
  logic                sat_clr;
  logic signed [7:0]   current_out;
  logic                current_valid;
  logic                sat_flag;

  spike_synapse_if #(.N_INPUTS(4), .WEIGHT_WIDTH(8)) wif ();

  spike_synapse #(
    .N_INPUTS(4), .WEIGHT_WIDTH(8), .CURRENT_WIDTH(8), .ACC_WIDTH(16), .DECAY_SHIFT(3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spike_in      (spike_in),
    .enable        (enable),
    .wr            (wif),
    .current_out   (current_out),
    .current_valid (current_valid),
    .sat_flag      (sat_flag),
    .sat_clr       (sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cur;
    int sat;
    int vld;
    int rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Reference model state: the values after the most recent clock edge.
  int m_w[4];
  int m_sum, m_acc, m_cur;
  int m_rdy, m_v1, m_v2, m_valid, m_sat;

  function automatic int floor_div(int a, int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_w[i] = 0;
    m_sum = 0; m_acc = 0; m_cur = 0;
    m_rdy = 1; m_v1 = 0; m_v2 = 0; m_valid = 0; m_sat = 0;
  endtask

  task automatic tick();
    int   full, nacc, ncur, nsum, clamp;
    exp_t e;
    full  = m_acc - floor_div(m_acc, 8) + m_sum * 256;
    clamp = 0;
    nacc  = full;
    if (full > 32767)  begin nacc = 32767;  clamp = 1; end
    if (full < -32768) begin nacc = -32768; clamp = 1; end
    ncur = floor_div(m_acc, 256);
    nsum = 0;
    for (int i = 0; i < 4; i++) if (spike_in[i] && enable) nsum += m_w[i];
    if (wif.w_valid && m_rdy != 0) begin
      m_w[wif.w_addr] = int'(wif.w_data);
      m_rdy = 0;
    end else begin
      m_rdy = 1;
    end
    m_sat   = (clamp != 0) ? 1 : (sat_clr ? 0 : m_sat);
    m_valid = (m_valid != 0 || m_v2 != 0) ? 1 : 0;
    m_v2    = m_v1;
    m_v1    = 1;
    m_sum   = nsum;
    m_acc   = nacc;
    m_cur   = ncur;
    @(posedge clk);
    e.cur = m_cur; e.sat = m_sat; e.vld = m_valid; e.rdy = m_rdy;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_current", current_out, e.cur);
      chk("sb_sat", {31'd0, sat_flag}, e.sat);
      chk("sb_valid", {31'd0, current_valid}, e.vld);
      chk("sb_wready", {31'd0, wif.w_ready}, e.rdy);
    end
  end

  task automatic write_w(input int addr, input int data);
    wif.w_valid = 1'b1;
    wif.w_addr  = 2'(addr);
    wif.w_data  = 8'(data);
    tick();
    wif.w_valid = 1'b0;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    rst_n = 1'b0; spike_in = '0; enable = 1'b1; sat_clr = 1'b0;
    wif.w_valid = 1'b0; wif.w_addr = '0; wif.w_data = '0;
    model_reset();
    #12;
    chk("rst_current", current_out, 0);
    chk("rst_valid", {31'd0, current_valid}, 0);
    chk("rst_sat", {31'd0, sat_flag}, 0);
    chk("rst_wready", {31'd0, wif.w_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Single spike and its decay
    write_w(0, 64);
    spike_in = 4'b0001; tick();
    spike_in = 4'b0000; tick(); tick();
    chk("spike_64", current_out, 64);
    tick(); chk("decay_56", current_out, 56);
    tick(); chk("decay_49", current_out, 49);
    idle(80);

    // Held w_valid: accepted on alternate cycles
    wif.w_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wif.w_addr = 2'(k);
      wif.w_data = 8'(11 * (k + 1));
      chk("hs_wready", {31'd0, wif.w_ready}, (k % 2 == 0) ? 1 : 0);
      tick();
    end
    wif.w_valid = 1'b0;
    tick();
    spike_in = 4'b1010; tick();
    spike_in = 4'b0000; tick(); tick();
    chk("hs_rejected", current_out, 0);
    idle(10);
    spike_in = 4'b0101; tick();
    spike_in = 4'b0000; tick(); tick();
    chk("hs_accepted", current_out, 44);
    idle(80);

    // Same-cycle write and spike on index 1
    write_w(1, 10);
    wif.w_valid = 1'b1; wif.w_addr = 2'd1; wif.w_data = 8'd100;
    spike_in = 4'b0010; tick();
    wif.w_valid = 1'b0; spike_in = 4'b0000; tick(); tick();
    chk("same_old_w", current_out, 10);
    idle(80);
    spike_in = 4'b0010; tick();
    spike_in = 4'b0000; tick(); tick();
    chk("same_new_w", current_out, 100);
    idle(80);

    // Positive saturation, clear priority, then clear
    for (int i = 0; i < 4; i++) write_w(i, 127);
    spike_in = 4'b1111;
    idle(6);
    chk("pos_sat_cur", current_out, 127);
    chk("pos_sat_flag", {31'd0, sat_flag}, 1);
    sat_clr = 1'b1; tick();
    chk("sat_set_prio", {31'd0, sat_flag}, 1);
    sat_clr = 1'b0; spike_in = 4'b0000;
    tick(); tick();
    sat_clr = 1'b1; tick();
    sat_clr = 1'b0;
    chk("sat_cleared", {31'd0, sat_flag}, 0);

    // Negative saturation, then enable low decays to zero
    for (int i = 0; i < 4; i++) write_w(i, -128);
    spike_in = 4'b1111;
    idle(5);
    chk("neg_sat_cur", current_out, -128);
    enable = 1'b0;
    for (int i = 0; i < 400; i++) begin
      prev = int'(current_out);
      tick();
      chk("decay_monotonic", {31'd0, (int'(current_out) >= prev)}, 1);
      if (current_out == 0) break;
    end
    chk("decay_to_zero", current_out, 0);
    idle(5);
    chk("decay_holds_zero", current_out, 0);

    // Reset mid-operation discards weights and in-flight sums
    enable = 1'b1;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_current", current_out, 0);
    chk("midrst_valid", {31'd0, current_valid}, 0);
    chk("midrst_sat", {31'd0, sat_flag}, 0);
    chk("midrst_wready", {31'd0, wif.w_ready}, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    idle(4);
    chk("postrst_current", current_out, 0);
    chk("postrst_valid", {31'd0, current_valid}, 1);

    spike_in = 4'b0000;
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
